// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch unit, instruction memory,
// execute (redirects) and decode (fetch-queue drain).
//   master (fetch unit): drives imem_req/imem_addr and the out_* head view,
//                        receives imem_rdata, redirect_* and out_ready.
//   slave  (environment): the mirror image.
interface fetch_unit_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned FETCH_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FETCH_DEPTH) + 1;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
  logic [CW-1:0]   fq_count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4, fq_count,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4, fq_count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with a decoupling fetch queue.
// Owns the PC, issues one sequential fetch per cycle to a one-cycle-latency
// instruction memory, buffers {instr, pc, pc+4} entries in a FETCH_DEPTH
// circular queue drained by decode, and flushes on execute redirects.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (wins over everything)
//   bus  - fetch_unit_if.master: imem_req/imem_addr/imem_rdata,
//          redirect_valid/redirect_pc, out_valid/out_ready/out_instr/
//          out_pc/out_pc4, fq_count
module fetch_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     FETCH_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  localparam int unsigned PW = $clog2(FETCH_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } fq_entry_t;

  fq_entry_t       fq_mem [FETCH_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic [CW:0]     limit;
  logic [XLEN-1:0] redirect_target;

  // Handshake decode; the pop credit lets the queue sustain one fetch per
  // cycle even when full-plus-inflight would otherwise block issue.
  always_comb begin
    pop             = bus.out_valid & bus.out_ready;
    occupancy       = (CW+1)'(count) + (CW+1)'(inflight);
    limit           = (CW+1)'(FETCH_DEPTH) + (CW+1)'(pop);
    issue           = !rst && !bus.redirect_valid && (occupancy < limit);
    push            = inflight & !bus.redirect_valid;
    redirect_target = bus.redirect_pc & ~XLEN'(3);
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = fq_mem[head].instr;
  assign bus.out_pc    = fq_mem[head].pc;
  assign bus.out_pc4   = fq_mem[head].pc4;
  assign bus.fq_count  = count;

  // PC, outstanding-request tracking and queue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < int'(FETCH_DEPTH); i++) begin
        fq_mem[i] <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
      end
      if (bus.redirect_valid) begin
        // Flush: the response arriving now belongs to the wrong path.
        pc    <= redirect_target;
        head  <= tail;
        count <= '0;
      end else begin
        if (issue) begin
          pc <= pc + XLEN'(4);
        end
        if (push) begin
          fq_mem[tail] <= '{instr: bus.imem_rdata, pc: req_pc, pc4: req_pc + XLEN'(4)};
          tail         <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a decoupling fetch queue. It owns the program counter, issues one sequential fetch per cycle to a one-cycle-latency instruction memory, and buffers returned {instr, pc, pc+4} entries in a FIFO of FETCH_DEPTH. Decode drains the FIFO with a valid/ready handshake, and execute redirects the stream on taken branches and jumps. It replaces the single-register PC/fetch stage. A stall is now expressed as backpressure, not a PC override, and in-flight wrong-path fetches are squashed.

## Interface
- XLEN, 32: address/PC width; instructions are always 32 bits.
- RESET_PC, 0: PC value loaded on reset; must be 4-byte aligned.
- FETCH_DEPTH, 4: fetch-queue entries; power of two, >= 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  XLEN  fetch address (current PC).
- imem_rdata  in  32  instruction for the request issued the previous cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0 internally.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_pc4  out  XLEN  head PC + 4.
- fq_count  out  $clog2(FETCH_DEPTH)+1  current queue occupancy.

## Operation
- **Pop.** pop = out_valid & out_ready. The head is removed at the edge.
- **Issue.** issue = !rst & !redirect_valid & (count + inflight < FETCH_DEPTH + pop).
  - imem_req = issue.
  - imem_addr = pc at all times.
- **PC update.**
  - On issue: pc <= pc + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
  - With no issue: pc holds.
- **Inflight.** inflight <= issue. At most one request is outstanding.
- **Push.** When inflight = 1 and no redirect this cycle, {imem_rdata, pc_of_request, pc_of_request+4} is written at the tail.
  - pc_of_request is kept in a register captured at issue.
- **Redirect** (highest priority, same edge):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Queue is flushed: count = 0, head = tail.
  - The response arriving this cycle is discarded.
  - No request is issued this cycle.
  - A pop in the redirect cycle still completes at the handshake, but the entry is wrong-path; decode is squashed by execute.
- **Queue.**
  - Circular buffer with head/tail pointers of $clog2(FETCH_DEPTH) bits, wrapping naturally.
  - Push and pop in the same cycle leave count unchanged.
  - The issue rule guarantees that a push into a full queue never occurs.
- **Outputs.**
  - out_* are driven directly from the head entry.
  - out_valid = (count != 0).
  - There is no bypass from imem_rdata to out_*.
- **Reset.** rst wins over redirect and everything else.
  - pc = RESET_PC; count, head, tail = 0; inflight = 0.
  - imem_req = 0; out_valid = 0; out_instr/out_pc/out_pc4 = 0; fq_count = 0.

## Timing
- Cycle 0 is the first cycle with rst low.
  - Request at RESET_PC in cycle 0.
  - Data in cycle 1, pushed at the end of cycle 1.
  - out_valid = 1 in cycle 2.
- Fetch-to-decode latency: 2 cycles.
- Redirect in cycle R:
  - Request to the target in cycle R+1.
  - Target entry visible at out_* in cycle R+3.
  - Penalty: 3 cycles.
- Steady state with out_ready = 1: one instruction per cycle for any FETCH_DEPTH >= 2.
  - This is achieved by crediting pop in the issue rule.
- Backpressure (out_ready = 0):
  - Queue fills to FETCH_DEPTH, then imem_req deasserts and pc holds.
  - On the first pop, issue resumes the same cycle.
- out_valid never drops while count != 0 and there is no redirect/reset; the head is stable under backpressure.
- Reset asserted mid-stream: all state is restored to reset values at the next edge, and the outstanding response is dropped.

## Test plan
- **Reset/startup.** FETCH_DEPTH=4, RESET_PC=0x100, out_ready=1.
  - imem_addr 0x100, 0x104, 0x108 in cycles 0..2.
  - out_pc 0x100 in cycle 2 with out_pc4 0x104; one entry per cycle thereafter.
- **Backpressure.** Hold out_ready=0 from cycle 0.
  - fq_count reaches 4 and imem_req stays 0 afterwards.
  - out_pc stays 0x100.
  - Raise out_ready: entries 0x100..0x10C drain in order with no gap, and the fetch resumes at 0x110.
- **Redirect.** At cycle 5 pulse redirect_valid with redirect_pc=0x2003.
  - fq_count = 0 in cycle 6.
  - imem_addr = 0x2000 in cycle 6.
  - out_pc = 0x2000 in cycle 8; no pre-redirect PCs appear after cycle 5.
- **Wrap.** RESET_PC=0xFFFFFFF8, free-running.
  - out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
  - out_pc4 of 0xFFFFFFFC is 0.
- **Collision.** Assert redirect and rst together mid-stream.
  - Next cycle: pc = RESET_PC and all outputs at reset values.
- **Random.** Random out_ready and redirects over 10k cycles, checked against a scoreboard.
  - Occupancy never exceeds FETCH_DEPTH.
  - PCs are sequential between redirects.
  - Each out_instr matches the memory model at out_pc.
